mux_n_pipe: RTL and testbench
=============================

Name: mux_n_pipe

Overview:
- Parametrised successor to the datapath's fixed 4-input 32-bit selector.
- N-input, W-bit mux with a valid/ready handshake on both sides.
- Two-entry skid stage gives full throughput with a registered in_ready.
- Out-of-range selector detection travels with each transfer.
- Sits between multicycle datapath stages where a source must be selected and held until the consumer accepts it.

Parameters:
- NUM_IN, 4, number of data inputs (2..16)
- WIDTH, 32, data width in bits (1..64)
- SEL_W, derived = max(1, clog2(NUM_IN)), selector width (localparam, not overridable)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- selector  in  SEL_W  input index; sampled only on an accepted transfer
- data_in  in  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  1  producer has a selection request
- in_ready  out  1  block can accept; registered
- data_out  out  WIDTH  selected data; registered
- sel_err  out  1  data_out came from an out-of-range selector; qualified by out_valid
- out_valid  out  1  data_out/sel_err valid
- out_ready  in  1  consumer accepts

Behaviour:
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Selection (combinational, applied at capture):
  - selector < NUM_IN: captures data_in[selector], err = 0.
  - selector >= NUM_IN (only possible when NUM_IN is not a power of 2): captures all-zero data, err = 1.
- Storage:
  - Main register: drives data_out, sel_err, out_valid.
  - Skid register: hidden, one entry.
- States: EMPTY, ONE (main full), TWO (main and skid full).
- Transitions:
  - EMPTY: input transfer -> load main -> ONE.
  - ONE, input only -> load skid -> TWO.
  - ONE, output only -> EMPTY.
  - ONE, input and output together -> load main with new data -> ONE.
  - TWO: input is never accepted. Output transfer -> skid moves to main -> ONE.
- in_ready is registered: 1 in next state EMPTY/ONE, 0 in TWO.
- out_valid = 1 in states ONE and TWO.
- Latency and ordering:
  - Data captured at edge k appears on data_out after edge k; minimum latency is 1 cycle.
  - Ordering is strict FIFO; no transfer is dropped or duplicated.
  - Sustained 1 transfer/cycle when out_ready is held high.
- While out_valid && !out_ready, data_out and sel_err are stable.
- in_valid and data_in are ignored when in_ready = 0.
- Reset (asynchronous, any time including mid-transfer):
  - state = EMPTY; in_ready = 1; out_valid = 0; data_out = 0; sel_err = 0; skid cleared.
  - In-flight data is discarded.
  - Release is synchronous to the clk edge following deassertion.

Optional Feature:
- Macro: MUX_N_PIPE_ERR_COUNT_EN.
- Defined:
  - Adds output err_count (16 bits).
  - Counts accepted input transfers with an out-of-range selector.
  - Saturates at 0xFFFF; reset value 0.
  - Increments on the same edge the transfer is captured.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Package mux_n_pipe_pkg holds:
  - state enum {EMPTY, ONE, TWO} as a 2-bit typedef
  - sel_width function (max(1, clog2(n)))
  - ERR_CNT_W = 16 constant
- Sub-module mux_n: purely combinational N-to-1 selector producing data and err. Reusable standalone and instantiated once at the capture point.

Test Plan:
- Reset, then NUM_IN=4 and WIDTH=32: data_in = {D,C,B,A}, selector=2, in_valid=1 for 1 cycle, out_ready=1 -> out_valid=1 the next cycle with data_out=C, sel_err=0, then 0.
- Back-pressure: out_ready=0, push A then B -> in_ready=0 after the 2nd accept and a 3rd push is held off. Raise out_ready -> outputs A then B in consecutive cycles, no loss or duplication.
- Throughput: out_ready=1, in_valid=1 for 100 cycles with random selector -> 100 outputs in order, one per cycle, values match a reference model.
- Out-of-range, NUM_IN=5: selector=7 -> data_out=0, sel_err=1. With MUX_N_PIPE_ERR_COUNT_EN defined, err_count increments 0 -> 1; after 70000 such transfers it holds 0xFFFF.
- Reset mid-operation: state TWO, assert reset asynchronously between edges -> out_valid=0, in_ready=1, data_out=0 immediately. After release, a new push of input 1 outputs input 1 with no stale data.
- Stall stability: out_valid=1 and out_ready=0 for 10 cycles while data_in and selector toggle -> data_out and sel_err remain unchanged.

Source files
------------

// File: rtl/mux_n_pipe_pkg.sv
// Shared types and helpers for the mux_n_pipe selector pipeline.
package mux_n_pipe_pkg;

  // Width of the saturating out-of-range counter.
  localparam int ERR_CNT_W = 16;

  // Occupancy of the two-entry output stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Selector width: clog2(n), never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-to-1 selector. Out-of-range selector gives zero data and o_err.
module mux_n #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]        i_selector,
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_err
);

  // Scan all legal indices; an unmatched selector keeps the zero/err default.
  always_comb begin
    o_data = '0;
    o_err  = 1'b1;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (i_selector == SEL_W'(i)) begin
        o_data = i_data[i*WIDTH +: WIDTH];
        o_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input W-bit selector with valid/ready on both sides and a two-entry skid
// stage (main + skid) giving full throughput with a registered in_ready.
// Optional build macro: MUX_N_PIPE_ERR_COUNT_EN adds the err_count output.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int WIDTH  = 32,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        selector,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err,
  output logic                    out_valid,
`ifdef MUX_N_PIPE_ERR_COUNT_EN
  output logic [ERR_CNT_W-1:0]    err_count,
`endif
  input  logic                    out_ready
);

  state_e             r_state;
  state_e             w_next;
  logic               r_in_ready;
  logic [WIDTH-1:0]   r_main_data;
  logic               r_main_err;
  logic [WIDTH-1:0]   r_skid_data;
  logic               r_skid_err;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_sel_err;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_load_main;
  logic               w_load_skid;
  logic               w_skid_to_main;

  mux_n #(
    .NUM_IN (NUM_IN),
    .WIDTH  (WIDTH),
    .SEL_W  (SEL_W)
  ) u_mux (
    .i_selector (selector),
    .i_data     (data_in),
    .o_data     (w_sel_data),
    .o_err      (w_sel_err)
  );

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state != EMPTY);
  assign data_out   = r_main_data;
  assign sel_err    = r_main_err;
  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = out_valid && out_ready;

  // State register; in_ready is precomputed from the next state so it is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != TWO);
    end
  end

  // Next-state and storage load enables.
  always_comb begin
    w_next         = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_load_main = 1'b1;
          w_next      = ONE;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid = 1'b1;
          w_next      = TWO;
        end else if (w_out_fire) begin
          w_next      = EMPTY;
        end
      end
      TWO: begin
        if (w_out_fire) begin
          w_skid_to_main = 1'b1;
          w_next         = ONE;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  // Main and skid data registers; main holds steady unless a load is enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_sel_data;
        r_main_err  <= w_sel_err;
      end else if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_err  <= w_sel_err;
      end
    end
  end

`ifdef MUX_N_PIPE_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] r_err_count;

  assign err_count = r_err_count;

  // Saturating count of accepted transfers with an out-of-range selector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (w_in_fire && w_sel_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench for mux_n_pipe: a 4x32 instance and a 5x8 instance
// (out-of-range selectors), each with a scoreboard queue filled on accepted
// inputs and drained on accepted outputs.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [1:0]   sel4;
  logic [127:0] din4;
  logic         iv4, ir4, se4, ov4, or4;
  logic [31:0]  do4;

  logic [2:0]   sel5;
  logic [39:0]  din5;
  logic         iv5, ir5, se5, ov5, or5;
  logic [7:0]   do5;

`ifdef MUX_N_PIPE_ERR_COUNT_EN
  logic [15:0]  ec4, ec5;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_out4   = 0;

  logic [32:0] q4[$];
  logic [8:0]  q5[$];
  logic [32:0] e4;
  logic [8:0]  e5;

  mux_n_pipe #(.NUM_IN(4), .WIDTH(32)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .selector  (sel4),
    .data_in   (din4),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .data_out  (do4),
    .sel_err   (se4),
    .out_valid (ov4),
`ifdef MUX_N_PIPE_ERR_COUNT_EN
    .err_count (ec4),
`endif
    .out_ready (or4)
  );

  mux_n_pipe #(.NUM_IN(5), .WIDTH(8)) u_dut5 (
    .clk       (clk),
    .reset     (reset),
    .selector  (sel5),
    .data_in   (din5),
    .in_valid  (iv5),
    .in_ready  (ir5),
    .data_out  (do5),
    .sel_err   (se5),
    .out_valid (ov5),
`ifdef MUX_N_PIPE_ERR_COUNT_EN
    .err_count (ec5),
`endif
    .out_ready (or5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference selection: shift the flattened bus down by sel words.
  function automatic logic [32:0] model4(input logic [1:0] s, input logic [127:0] d);
    logic [127:0] t;
    t = d >> (32 * s);
    return {1'b0, t[31:0]};
  endfunction

  function automatic logic [8:0] model5(input logic [2:0] s, input logic [39:0] d);
    logic [39:0] t;
    if (s > 3'd4) return {1'b1, 8'h00};
    t = d >> (8 * s);
    return {1'b0, t[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: inputs are stable mid-cycle, so handshakes are judged at negedge.
  always @(negedge clk) begin
    if (reset) begin
      if (ov4 && or4) begin
        check("dut4 output pending", 64'(q4.size() != 0), 64'(1));
        if (q4.size() != 0) begin
          e4 = q4.pop_front();
          check("dut4 data", 64'(do4), 64'(e4[31:0]));
          check("dut4 sel_err", 64'(se4), 64'(e4[32]));
        end
        n_out4++;
      end
      if (iv4 && ir4) q4.push_back(model4(sel4, din4));
      if (ov5 && or5) begin
        check("dut5 output pending", 64'(q5.size() != 0), 64'(1));
        if (q5.size() != 0) begin
          e5 = q5.pop_front();
          check("dut5 data", 64'(do5), 64'(e5[7:0]));
          check("dut5 sel_err", 64'(se5), 64'(e5[8]));
        end
      end
      if (iv5 && ir5) q5.push_back(model5(sel5, din5));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a_val, b_val;
    int n0;

    sel4 = '0; din4 = '0; iv4 = 1'b0; or4 = 1'b0;
    sel5 = '0; din5 = '0; iv5 = 1'b0; or5 = 1'b0;

    // Reset values
    #12;
    check("rst in_ready", 64'(ir4), 64'(1));
    check("rst out_valid", 64'(ov4), 64'(0));
    check("rst data_out", 64'(do4), 64'(0));
    check("rst sel_err", 64'(se4), 64'(0));
`ifdef MUX_N_PIPE_ERR_COUNT_EN
    check("rst err_count", 64'(ec5), 64'(0));
`endif
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single transfer, selector=2
    din4 = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    sel4 = 2'd2; iv4 = 1'b1; or4 = 1'b1;
    tick();
    iv4 = 1'b0;
    check("single out_valid", 64'(ov4), 64'(1));
    check("single data_out", 64'(do4), 64'(32'hCCCC0003));
    check("single sel_err", 64'(se4), 64'(0));
    tick();
    check("single out_valid drop", 64'(ov4), 64'(0));

    // Back-pressure: two accepts fill the stage, third push held off
    or4 = 1'b0;
    din4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    a_val = din4[31:0];
    b_val = din4[63:32];
    sel4 = 2'd0; iv4 = 1'b1;
    tick();
    check("bp in_ready after 1st", 64'(ir4), 64'(1));
    sel4 = 2'd1;
    tick();
    check("bp in_ready after 2nd", 64'(ir4), 64'(0));
    sel4 = 2'd2;
    // Stall stability while inputs toggle
    for (int i = 0; i < 10; i++) begin
      din4 = {$urandom(), $urandom(), $urandom(), $urandom()};
      sel4 = 2'($urandom_range(0, 3));
      tick();
      check("stall data_out", 64'(do4), 64'(a_val));
      check("stall sel_err", 64'(se4), 64'(0));
      check("stall in_ready", 64'(ir4), 64'(0));
    end
    iv4 = 1'b0; or4 = 1'b1;
    #1;
    check("bp first out", 64'(do4), 64'(a_val));
    tick();
    check("bp second valid", 64'(ov4), 64'(1));
    check("bp second out", 64'(do4), 64'(b_val));
    tick();
    check("bp drained", 64'(ov4), 64'(0));

    // Throughput: 100 back-to-back transfers
    n0 = n_out4;
    for (int i = 0; i < 100; i++) begin
      din4 = {$urandom(), $urandom(), $urandom(), $urandom()};
      sel4 = 2'($urandom_range(0, 3));
      iv4 = 1'b1;
      tick();
      check("tp in_ready", 64'(ir4), 64'(1));
      check("tp out_valid", 64'(ov4), 64'(1));
    end
    iv4 = 1'b0;
    for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
    tick();
    check("tp output count", 64'(n_out4 - n0), 64'(100));
    check("tp queue drained", 64'(q4.size()), 64'(0));

    // Out-of-range selector on the 5-input instance
    or5 = 1'b1;
    din5 = {$urandom(), 8'($urandom())};
    sel5 = 3'd7; iv5 = 1'b1;
    tick();
    iv5 = 1'b0;
    check("oor out_valid", 64'(ov5), 64'(1));
    check("oor data_out", 64'(do5), 64'(0));
    check("oor sel_err", 64'(se5), 64'(1));
`ifdef MUX_N_PIPE_ERR_COUNT_EN
    check("oor err_count", 64'(ec5), 64'(1));
`endif
    // Boundary selectors through the scoreboard: 4 legal, 5 illegal
    for (int i = 0; i < 6; i++) begin
      din5 = {$urandom(), 8'($urandom())};
      sel5 = (i % 2 == 0) ? 3'd4 : 3'd5;
      iv5 = 1'b1;
      tick();
    end
    iv5 = 1'b0;
    tick();
    tick();
`ifdef MUX_N_PIPE_ERR_COUNT_EN
    check("err_count after boundary", 64'(ec5), 64'(4));
    sel5 = 3'd7; iv5 = 1'b1;
    for (int i = 0; i < 65600; i++) tick();
    iv5 = 1'b0;
    tick();
    check("err_count saturated", 64'(ec5), 64'(16'hFFFF));
    check("err_count in-range only", 64'(ec4), 64'(0));
    tick();
`endif
    check("oor queue drained", 64'(q5.size()), 64'(0));

    // Asynchronous reset mid-operation with the stage full
    or4 = 1'b0;
    din4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    sel4 = 2'd3; iv4 = 1'b1;
    tick();
    tick();
    iv4 = 1'b0;
    check("pre-reset full", 64'(ir4), 64'(0));
    #2;
    reset = 1'b0;
    #1;
    check("async rst out_valid", 64'(ov4), 64'(0));
    check("async rst in_ready", 64'(ir4), 64'(1));
    check("async rst data_out", 64'(do4), 64'(0));
    check("async rst sel_err", 64'(se4), 64'(0));
    q4.delete();
    q5.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
    din4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    a_val = din4[63:32];
    sel4 = 2'd1; iv4 = 1'b1; or4 = 1'b1;
    tick();
    iv4 = 1'b0;
    check("post-rst out_valid", 64'(ov4), 64'(1));
    check("post-rst data_out", 64'(do4), 64'(a_val));
    tick();
    check("post-rst no stale", 64'(ov4), 64'(0));
    check("final queue4", 64'(q4.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
